sp_addsub_sched: RTL and testbench

Round-robin scheduler sharing one integer add/subtract datapath (adder and subtractor, WIDTH bits) among PORTS requesters. Each requester presents an opcode and two operands with a valid/ready handshake. The block grants one request per cycle, computes through the shared adder/subtractor and holds the result in a single output register tagged with the requester index. It sits between kernel-generated operator call sites and the shared integer arithmetic resource, so several call sites can use one physical unit.

---
 rtl/sp_addsub_sched_pkg.sv | 19 +
 rtl/sp_addsub_sched_if.sv | 35 +++
 rtl/sp_int_add.sv | 16 +
 rtl/sp_int_sub.sv | 16 +
 rtl/sp_rr_arbiter.sv | 46 ++++
 rtl/sp_addsub_sched.sv | 101 ++++++++++
 tb/tb_sp_addsub_sched.sv | 205 ++++++++++++++++++++
 7 files changed

// File: rtl/sp_addsub_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sp_addsub_sched_pkg
//  Description : Shared opcode constants and helpers for schedulers that
//                share integer arithmetic operators.
//  Revision    : 1.0 - initial release
// ============================================================================
package sp_addsub_sched_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Width needed to index n ports; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_addsub_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : sp_addsub_sched_if
//  Description : Request/result bundle between requesters, the consumer and
//                the shared add/subtract scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sp_addsub_sched_if #(
    parameter int WIDTH = 32,
    parameter int PORTS = 4,
    parameter int IDW   = 2
);
    logic [PORTS-1:0]       req_valid;
    logic [PORTS-1:0]       req_ready;
    logic [PORTS-1:0]       req_op;
    logic [PORTS*WIDTH-1:0] req_a;
    logic [PORTS*WIDTH-1:0] req_b;
    logic                   res_valid;
    logic                   res_ready;
    logic [WIDTH-1:0]       res_data;
    logic [IDW-1:0]         res_id;

    // Requester / consumer side.
    modport master (
        output req_valid, req_op, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_op, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id
    );
endinterface
`default_nettype wire

// File: rtl/sp_int_add.sv
`default_nettype none
// ============================================================================
//  Module      : sp_int_add
//  Description : Integer adder, result modulo 2^WIDTH, no carry out.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_int_add #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic      [WIDTH-1:0] o_sum
);
    assign o_sum = i_a + i_b;
endmodule
`default_nettype wire

// File: rtl/sp_int_sub.sv
`default_nettype none
// ============================================================================
//  Module      : sp_int_sub
//  Description : Integer subtractor (a - b), two's complement, modulo 2^WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_int_sub #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic      [WIDTH-1:0] o_diff
);
    assign o_diff = i_a - i_b;
endmodule
`default_nettype wire

// File: rtl/sp_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sp_rr_arbiter
//  Description : Combinational round-robin arbiter. Scans requests starting at
//                the pointer with wrap-around; emits one-hot grant and index.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_rr_arbiter
    import sp_addsub_sched_pkg::*;
#(
    parameter  int PORTS  = 4,
    localparam int c_IDXW = idx_width(PORTS)
) (
    input  wire logic [PORTS-1:0]  i_req,
    input  wire logic [c_IDXW-1:0] i_ptr,
    input  wire logic              i_en,
    output logic      [PORTS-1:0]  o_grant,
    output logic      [c_IDXW-1:0] o_idx
);

    // First requester at or after the pointer wins; nothing granted when disabled.
    always_comb begin
        logic              w_found;
        int                w_pos;
        logic [c_IDXW-1:0] w_j;
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_j     = '0;
        for (int k = 0; k < PORTS; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= PORTS) begin
                w_pos = w_pos - PORTS;
            end
            w_j = c_IDXW'(w_pos);
            if (i_en && !w_found && i_req[w_j]) begin
                w_found      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sp_addsub_sched.sv
`default_nettype none
// ============================================================================
//  Module      : sp_addsub_sched
//  Description : Round-robin scheduler sharing one add/subtract datapath among
//                PORTS requesters; one registered, port-tagged result.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_addsub_sched
    import sp_addsub_sched_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PORTS = 4,
    parameter int IDW   = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sp_addsub_sched_if.slave   bus
);

    localparam int c_IDXW = idx_width(PORTS);

    logic [c_IDXW-1:0] r_ptr;
    logic              r_valid;
    logic [WIDTH-1:0]  r_data;
    logic [IDW-1:0]    r_id;

    logic              w_free;
    logic              w_en;
    logic [PORTS-1:0]  w_grant;
    logic [c_IDXW-1:0] w_idx;
    logic              w_accept;
    logic              w_op;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [WIDTH-1:0]  w_sum;
    logic [WIDTH-1:0]  w_diff;
    logic [WIDTH-1:0]  w_res;

    // The output register can take a new result when empty or being drained.
    assign w_free = !r_valid || bus.res_ready;
    assign w_en   = w_free && !rst;

    sp_rr_arbiter #(
        .PORTS   (PORTS)
    ) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_en),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign bus.req_ready = w_grant;
    assign w_accept      = |(w_grant & bus.req_valid);

    // Operand/opcode steering from the granted port.
    assign w_op = bus.req_op[w_idx];
    assign w_a  = bus.req_a[int'(w_idx)*WIDTH +: WIDTH];
    assign w_b  = bus.req_b[int'(w_idx)*WIDTH +: WIDTH];

    sp_int_add #(
        .WIDTH (WIDTH)
    ) u_add (
        .i_a   (w_a),
        .i_b   (w_b),
        .o_sum (w_sum)
    );

    sp_int_sub #(
        .WIDTH  (WIDTH)
    ) u_sub (
        .i_a    (w_a),
        .i_b    (w_b),
        .o_diff (w_diff)
    );

    assign w_res = (w_op == OP_SUB) ? w_diff : w_sum;

    // Result register and round-robin pointer; pointer moves past each winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_res;
            r_id    <= IDW'(w_idx);
            r_ptr   <= (w_idx == c_IDXW'(PORTS-1)) ? '0 : w_idx + 1'b1;
        end else if (bus.res_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.res_valid = r_valid;
    assign bus.res_data  = r_data;
    assign bus.res_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_sp_addsub_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sp_addsub_sched
//  Description : Scoreboard bench for sp_addsub_sched with a behavioural
//                model of pending requests, grant pointer and result slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_addsub_sched;
    localparam int WIDTH = 32;
    localparam int PORTS = 4;
    localparam int IDW   = 2;

    typedef struct {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sp_addsub_sched_if #(.WIDTH(WIDTH), .PORTS(PORTS), .IDW(IDW)) bus ();

    sp_addsub_sched #(.WIDTH(WIDTH), .PORTS(PORTS), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];

    // Model state: pending requests per port, output slot occupancy, pointer.
    bit               pv [PORTS];
    bit               pop[PORTS];
    logic [WIDTH-1:0] pa [PORTS];
    logic [WIDTH-1:0] pb [PORTS];
    bit               m_valid = 1'b0;
    int               m_ptr   = 0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic [WIDTH-1:0] rand_val();
        case ($urandom_range(7))
            0:       return '0;
            1:       return '1;
            2:       return WIDTH'($urandom_range(15));
            default: return WIDTH'($urandom());
        endcase
    endfunction

    task automatic set_req(input int p, input bit op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        pv[p] = 1'b1; pop[p] = op; pa[p] = a; pb[p] = b;
    endtask

    // One clock cycle: drive at the falling edge, check combinational ready,
    // advance the model, then wait for the next falling edge.
    task automatic step(input int req_pct, input int rdy_pct, input bit do_rst);
        bit               rr;
        int               g;
        int               j;
        logic [PORTS-1:0] exp_rdy;
        logic [WIDTH-1:0] r;
        for (int i = 0; i < PORTS; i++) begin
            if (!pv[i] && ($urandom_range(99) < req_pct))
                set_req(i, 1'($urandom_range(1)), rand_val(), rand_val());
        end
        rr            = ($urandom_range(99) < rdy_pct);
        rst           = do_rst;
        bus.res_ready = rr;
        for (int i = 0; i < PORTS; i++) begin
            bus.req_valid[i]            = pv[i];
            bus.req_op[i]               = pop[i];
            bus.req_a[i*WIDTH +: WIDTH] = pa[i];
            bus.req_b[i*WIDTH +: WIDTH] = pb[i];
        end
        #1;
        chk("res_valid", 64'(bus.res_valid), 64'(m_valid));
        g = -1;
        if (!do_rst && (!m_valid || rr)) begin
            for (int k = 0; k < PORTS; k++) begin
                j = (m_ptr + k) % PORTS;
                if (g < 0 && pv[j]) g = j;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        if (do_rst) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            q.delete();
        end else if (g >= 0) begin
            r = pop[g] ? (pa[g] - pb[g]) : (pa[g] + pb[g]);
            q.push_back('{IDW'(g), r});
            m_valid = 1'b1;
            m_ptr   = (g + 1) % PORTS;
            pv[g]   = 1'b0;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    // Monitor: on each completed result handshake compare against the queue head.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL res_unexpected got id %0d data %0h expected none", bus.res_id, bus.res_data);
            end else begin
                e = q.pop_front();
                chk("res_id",   64'(bus.res_id),   64'(e.id));
                chk("res_data", 64'(bus.res_data), 64'(e.data));
            end
        end
    end

    initial begin
        for (int i = 0; i < PORTS; i++) set_req(i, 1'b0, WIDTH'(i), WIDTH'(i));
        bus.req_valid = '1;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_data",  64'(bus.res_data),  64'd0);
        chk("rst_res_id",    64'(bus.res_id),    64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        step(0, 0, 1'b1);
        for (int i = 0; i < PORTS; i++) pv[i] = 1'b0;

        // Single add on port 2.
        set_req(2, 1'b0, 32'd5, 32'd7);
        step(0, 100, 1'b0);
        step(0, 100, 1'b0);
        chk("single_add_data", 64'(bus.res_data), 64'd12);

        // Wrap-around arithmetic on port 0.
        set_req(0, 1'b1, 32'd3, 32'd5);
        step(0, 100, 1'b0);
        set_req(0, 1'b0, 32'hFFFF_FFFF, 32'd2);
        step(0, 100, 1'b0);
        step(0, 100, 1'b0);
        repeat (2) step(0, 100, 1'b0);

        // Round-robin with every port continuously valid, from a fresh pointer.
        step(0, 100, 1'b1);
        repeat (10) step(100, 100, 1'b0);
        repeat (3) step(0, 100, 1'b0);

        // Backpressure: full slot, ports 1 and 3 waiting, consumer stalled.
        set_req(0, 1'b0, 32'd1, 32'd1);
        step(0, 100, 1'b0);
        set_req(1, 1'b0, 32'd10, 32'd20);
        set_req(3, 1'b1, 32'd10, 32'd20);
        repeat (3) step(0, 0, 1'b0);
        repeat (4) step(0, 100, 1'b0);

        // Back-to-back, alternating ports 0 and 1.
        repeat (8) begin
            for (int i = 0; i < 2; i++)
                if (!pv[i]) set_req(i, 1'($urandom_range(1)), rand_val(), rand_val());
            step(0, 100, 1'b0);
        end
        repeat (3) step(0, 100, 1'b0);

        // Reset while a result is stalled; ports 3 and 1 keep requesting.
        set_req(2, 1'b0, 32'd9, 32'd9);
        step(0, 0, 1'b0);
        set_req(3, 1'b0, 32'd4, 32'd4);
        set_req(1, 1'b1, 32'd4, 32'd1);
        step(0, 0, 1'b0);
        step(0, 0, 1'b1);
        step(0, 100, 1'b0);
        repeat (4) step(0, 100, 1'b0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            step(int'($urandom_range(100)), int'($urandom_range(100)), ($urandom_range(199) == 0));
        end

        repeat (6) step(0, 100, 1'b0);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
